// File: rtl/serial_pack_sequencer_if.sv
// serial_pack_sequencer_if
// Bundles the UART-side byte/handshake signals and the serial-out channel
// load bus of serial_pack_sequencer.
//   i_data, i_rx_done_tick : received byte and its one-cycle strobe
//   i_tx_done_tick         : UART transmitter finished a byte
//   i_ch_busy              : per-channel "shifting out" flags
//   o_output_pattern/o_freq_pattern/o_load : channel load bus
//   o_tx_start/o_tx_data   : reply byte request
//   o_timeout_tick/o_drop_tick : status strobes
// slave is the sequencer side, master is the surrounding system side.
interface serial_pack_sequencer_if #(
    parameter int DATA_BIT = 32,
    parameter int CH_NUM   = 3
);
    logic [7:0]          i_data;
    logic                i_rx_done_tick;
    logic                i_tx_done_tick;
    logic [CH_NUM-1:0]   i_ch_busy;
    logic [DATA_BIT-1:0] o_output_pattern;
    logic [DATA_BIT-1:0] o_freq_pattern;
    logic [CH_NUM-1:0]   o_load;
    logic                o_tx_start;
    logic [7:0]          o_tx_data;
    logic                o_timeout_tick;
    logic                o_drop_tick;

    modport slave (
        input  i_data, i_rx_done_tick, i_tx_done_tick, i_ch_busy,
        output o_output_pattern, o_freq_pattern, o_load, o_tx_start, o_tx_data,
               o_timeout_tick, o_drop_tick
    );

    modport master (
        output i_data, i_rx_done_tick, i_tx_done_tick, i_ch_busy,
        input  o_output_pattern, o_freq_pattern, o_load, o_tx_start, o_tx_data,
               o_timeout_tick, o_drop_tick
    );
endinterface

// File: rtl/serial_pack_sequencer.sv
// serial_pack_sequencer
// Assembles UART bytes into command packs (output pattern, frequency pattern,
// control byte; patterns LSB byte first), validates each pack, loads the
// addressed serial-out channel and answers with an ACK or NAK byte.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_pack_sequencer_if.slave (UART byte/handshake in, channel
//           load bus, reply byte and status strobes out)
module serial_pack_sequencer #(
    parameter int         DATA_BIT    = 32,
    parameter int         PACK_NUM    = (DATA_BIT / 8) * 2 + 1,
    parameter int         CH_NUM      = 3,
    parameter int         TIMEOUT_CYC = 52083,
    parameter logic [7:0] ACK_BYTE    = 8'hA5,
    parameter logic [7:0] NAK_BYTE    = 8'h5A
) (
    input logic                clk,
    input logic                rst_n,
    serial_pack_sequencer_if.slave bus
);
    localparam int HOLD_W = PACK_NUM * 8;
    localparam int CNT_W  = (PACK_NUM > 1) ? $clog2(PACK_NUM) : 1;
    localparam int TMR_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PACK_NUM - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StRecv   = 3'd1;
    localparam logic [2:0] StCheck  = 3'd2;
    localparam logic [2:0] StLoad   = 3'd3;
    localparam logic [2:0] StReply  = 3'd4;
    localparam logic [2:0] StWaitTx = 3'd5;

    logic [2:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [DATA_BIT-1:0] out_pat_q, out_pat_d;
    logic [DATA_BIT-1:0] freq_pat_q, freq_pat_d;
    logic [7:0]          tx_data_q, tx_data_d;

    logic [7:0] ctrl;
    logic [1:0] ch;
    logic [3:0] busy_ext;
    logic       ch_ok;
    logic       reject;
    logic       accepting;
    logic       timeout;

    // The newest byte enters at the top, so after a full pack byte 0 sits in
    // the low bits and the control byte occupies the top byte.
    assign ctrl     = hold_q[HOLD_W-1 -: 8];
    assign ch       = ctrl[1:0];
    assign busy_ext = 4'(bus.i_ch_busy);
    assign ch_ok    = int'(ch) < CH_NUM;
    assign reject   = !ch_ok || (ctrl[7:2] != 6'd0) || busy_ext[ch];

    assign accepting = (state_q == StIdle) || (state_q == StRecv);
    // A byte arriving on the expiry cycle wins over the timeout.
    assign timeout   = (state_q == StRecv) && !bus.i_rx_done_tick && (tmr_q == TMR_LAST);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tmr_d      = tmr_q;
        hold_d     = hold_q;
        out_pat_d  = out_pat_q;
        freq_pat_d = freq_pat_q;
        tx_data_d  = tx_data_q;
        case (state_q)
            StIdle, StRecv: begin
                if (bus.i_rx_done_tick) begin
                    hold_d = HOLD_W'({bus.i_data, hold_q} >> 8);
                    tmr_d  = '0;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = StCheck;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = StRecv;
                    end
                end else if (timeout) begin
                    cnt_d   = '0;
                    tmr_d   = '0;
                    hold_d  = '0;
                    state_d = StIdle;
                end else if (state_q == StRecv) begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            StCheck: begin
                if (reject) begin
                    tx_data_d = NAK_BYTE;
                    state_d   = StReply;
                end else begin
                    // Registered here so the patterns are already valid
                    // during the o_load cycle.
                    out_pat_d  = hold_q[DATA_BIT-1:0];
                    freq_pat_d = hold_q[2*DATA_BIT-1:DATA_BIT];
                    state_d    = StLoad;
                end
            end
            StLoad: begin
                tx_data_d = ACK_BYTE;
                state_d   = StReply;
            end
            StReply: begin
                state_d = StWaitTx;
            end
            StWaitTx: begin
                if (bus.i_tx_done_tick) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            tmr_q      <= '0;
            hold_q     <= '0;
            out_pat_q  <= '0;
            freq_pat_q <= '0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tmr_q      <= tmr_d;
            hold_q     <= hold_d;
            out_pat_q  <= out_pat_d;
            freq_pat_q <= freq_pat_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign bus.o_output_pattern = out_pat_q;
    assign bus.o_freq_pattern   = freq_pat_q;
    assign bus.o_load           = (state_q == StLoad) ? (CH_NUM'(1) << ch) : '0;
    assign bus.o_tx_start       = (state_q == StReply);
    assign bus.o_tx_data        = tx_data_q;
    assign bus.o_timeout_tick   = timeout;
    assign bus.o_drop_tick      = bus.i_rx_done_tick && !accepting;
endmodule

// File: tb/tb_serial_pack_sequencer.sv
// Testbench for serial_pack_sequencer: directed packs from the test plan plus
// randomized packs, timeouts, drops and busy flags, checked every cycle
// against a transaction-level model of the expected output schedule.
module tb_serial_pack_sequencer;
    localparam int DB = 32;
    localparam int CH = 3;
    localparam int TO = 40;
    localparam int PN = 9;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_pack_sequencer_if #(.DATA_BIT(DB), .CH_NUM(CH)) bus ();

    serial_pack_sequencer #(
        .DATA_BIT(DB), .PACK_NUM(PN), .CH_NUM(CH), .TIMEOUT_CYC(TO),
        .ACK_BYTE(8'hA5), .NAK_BYTE(8'h5A)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Expected output schedule, keyed by cycle number.
    logic [2:0]  e_load [int];
    bit          e_tx   [int];
    logic [7:0]  e_txd  [int];
    bit          e_to   [int];
    bit          e_drop [int];
    logic [63:0] e_pat  [int];
    logic [63:0] cur_pat = '0;

    // Transaction-level model state.
    logic [7:0] pbuf [PN];
    int  nbytes = 0;
    int  last_c = 0;
    int  eval_c = -1;
    int  tx_c = -1;
    bit  accepting = 1'b1;
    bit  rand_busy = 1'b0;
    int  last_t = 0;
    logic [7:0] pk [PN];

    task automatic model_clear();
        e_load.delete(); e_tx.delete(); e_txd.delete();
        e_to.delete(); e_drop.delete(); e_pat.delete();
        cur_pat = '0; nbytes = 0; eval_c = -1; tx_c = -1; accepting = 1'b1;
    endtask

    // Called once per cycle with that cycle's inputs.
    task automatic model(input int c);
        logic [7:0]  ctl;
        logic [3:0]  bx;
        logic [31:0] op, fp;
        bit ok;
        if (!rst_n) return;
        if (eval_c == c) begin
            ctl = pbuf[PN-1];
            bx  = 4'(bus.i_ch_busy);
            ok  = (int'(ctl[1:0]) < CH) && (ctl[7:2] == 6'd0) && !bx[ctl[1:0]];
            op  = {pbuf[3], pbuf[2], pbuf[1], pbuf[0]};
            fp  = {pbuf[7], pbuf[6], pbuf[5], pbuf[4]};
            if (ok) begin
                e_load[c+1] = 3'b001 << ctl[1:0];
                e_pat[c+1]  = {fp, op};
                tx_c = c + 2;
                e_txd[tx_c] = 8'hA5;
            end else begin
                tx_c = c + 1;
                e_txd[tx_c] = 8'h5A;
            end
            e_tx[tx_c] = 1'b1;
            eval_c = -1;
        end
        if (bus.i_rx_done_tick) begin
            if (!accepting) begin
                e_drop[c] = 1'b1;
            end else begin
                if (nbytes > 0) begin
                    if (c > last_c + TO) nbytes = 0;
                    else e_to.delete(last_c + TO);
                end
                pbuf[nbytes] = bus.i_data;
                nbytes++;
                last_c = c;
                if (nbytes == PN) begin
                    nbytes = 0; accepting = 1'b0; eval_c = c + 1; tx_c = -1;
                end else begin
                    e_to[c+TO] = 1'b1;
                end
            end
        end
        if (bus.i_tx_done_tick && !accepting && tx_c >= 0 && c > tx_c) accepting = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_patterns", {bus.o_freq_pattern, bus.o_output_pattern}, 64'd0);
            chk("reset_strobes", {bus.o_load, bus.o_tx_start, bus.o_tx_data,
                bus.o_timeout_tick, bus.o_drop_tick}, 64'd0);
        end else begin
            if (e_pat.exists(cyc)) cur_pat = e_pat[cyc];
            chk("load", bus.o_load, e_load.exists(cyc) ? e_load[cyc] : 3'b000);
            chk("tx_start", bus.o_tx_start, e_tx.exists(cyc) ? 1'b1 : 1'b0);
            chk("timeout_tick", bus.o_timeout_tick, e_to.exists(cyc) ? 1'b1 : 1'b0);
            chk("drop_tick", bus.o_drop_tick, e_drop.exists(cyc) ? 1'b1 : 1'b0);
            chk("patterns", {bus.o_freq_pattern, bus.o_output_pattern}, cur_pat);
            if (e_tx.exists(cyc)) chk("tx_data", bus.o_tx_data, e_txd[cyc]);
        end
    end

    task automatic step(input bit rx, input logic [7:0] d, input bit txd);
        bus.i_rx_done_tick = rx;
        bus.i_data         = d;
        bus.i_tx_done_tick = txd;
        if (rand_busy) bus.i_ch_busy = 3'($urandom);
        model(cyc);
        @(posedge clk);
        #1;
        bus.i_rx_done_tick = 1'b0;
        bus.i_tx_done_tick = 1'b0;
    endtask

    task automatic idle_to(input int c);
        while (cyc < c) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic at_cycle(input int c);
        idle_to(c);
        @(negedge clk);
    endtask

    task automatic make_pack(input logic [31:0] op, input logic [31:0] fp, input logic [7:0] ctl);
        for (int i = 0; i < 4; i++) begin
            pk[i]   = op[8*i +: 8];
            pk[i+4] = fp[8*i +: 8];
        end
        pk[8] = ctl;
    endtask

    task automatic send_bytes(input int n, input int maxgap, input bit wild);
        int g;
        for (int i = 0; i < n; i++) begin
            last_t = cyc;
            step(1'b1, pk[i], 1'b0);
            if (i < n - 1) begin
                g = $urandom_range(0, maxgap);
                if (wild) begin
                    case ($urandom_range(0, 19))
                        0: g = TO - 1;
                        1: g = TO;
                        default: ;
                    endcase
                end
                repeat (g) step(1'b0, 8'h00, 1'b0);
            end
        end
    endtask

    // Lets the reply go out and acts as the UART by returning i_tx_done_tick.
    task automatic finish_reply(input bit noisy);
        int target;
        while (eval_c >= 0) step(1'b0, 8'h00, 1'b0);
        target = tx_c + $urandom_range(1, 4);
        while (cyc < target) step(noisy && ($urandom_range(0, 3) == 0), 8'($urandom), 1'b0);
        step(noisy && ($urandom_range(0, 3) == 0), 8'($urandom), 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        @(negedge clk);
        chk("lit_reset_load", bus.o_load, 3'b000);
        chk("lit_reset_pattern", bus.o_output_pattern, 32'd0);
        #1;
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t;
        bus.i_data = '0; bus.i_rx_done_tick = 1'b0;
        bus.i_tx_done_tick = 1'b0; bus.i_ch_busy = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b0);

        // Valid pack for channel 1.
        make_pack(32'h12345678, 32'h9ABCDEF0, 8'h01);
        send_bytes(PN, 2, 1'b0);
        t = last_t;
        at_cycle(t + 2);
        chk("lit_load", bus.o_load, 3'b010);
        chk("lit_out_pat", bus.o_output_pattern, 32'h12345678);
        chk("lit_freq_pat", bus.o_freq_pattern, 32'h9ABCDEF0);
        #1;
        at_cycle(t + 3);
        chk("lit_ack_start", bus.o_tx_start, 1'b1);
        chk("lit_ack_data", bus.o_tx_data, 8'hA5);
        #1;
        finish_reply(1'b0);

        // Same pack with channel 1 busy: NAK two cycles after the last byte.
        bus.i_ch_busy = 3'b010;
        send_bytes(PN, 1, 1'b0);
        t = last_t;
        at_cycle(t + 2);
        chk("lit_nak_start", bus.o_tx_start, 1'b1);
        chk("lit_nak_data", bus.o_tx_data, 8'h5A);
        chk("lit_nak_load", bus.o_load, 3'b000);
        #1;
        bus.i_ch_busy = 3'b000;
        finish_reply(1'b0);

        // Out-of-range channel and reserved control bits.
        make_pack(32'hCAFEF00D, 32'h0BADBEEF, 8'h03);
        send_bytes(PN, 1, 1'b0);
        finish_reply(1'b0);
        make_pack(32'hCAFEF00D, 32'h0BADBEEF, 8'h81);
        send_bytes(PN, 1, 1'b0);
        t = last_t;
        at_cycle(t + 2);
        chk("lit_rsvd_nak", bus.o_tx_data, 8'h5A);
        chk("lit_keep_pat", bus.o_output_pattern, 32'h12345678);
        #1;
        finish_reply(1'b0);

        // Timeout on a 4-byte partial pack, then a clean pack for channel 0.
        make_pack(32'hDEADDEAD, 32'hDEADDEAD, 8'h02);
        send_bytes(4, 1, 1'b0);
        t = last_t;
        at_cycle(t + TO - 1);
        chk("lit_no_timeout_early", bus.o_timeout_tick, 1'b0);
        #1;
        at_cycle(t + TO);
        chk("lit_timeout", bus.o_timeout_tick, 1'b1);
        #1;
        idle_to(t + TO + 3);
        make_pack(32'h44332211, 32'h88776655, 8'h00);
        send_bytes(PN, 0, 1'b0);
        t = last_t;
        at_cycle(t + 2);
        chk("lit_load_ch0", bus.o_load, 3'b001);
        chk("lit_out_after_to", bus.o_output_pattern, 32'h44332211);
        #1;
        finish_reply(1'b0);

        // Drop during WAIT_TX and a byte coinciding with i_tx_done_tick.
        make_pack(32'h01020304, 32'h05060708, 8'h02);
        send_bytes(PN, 1, 1'b0);
        while (eval_c >= 0) step(1'b0, 8'h00, 1'b0);
        idle_to(tx_c + 1);
        bus.i_rx_done_tick = 1'b1;
        bus.i_data = 8'h77;
        model(cyc);
        @(negedge clk);
        chk("lit_drop", bus.o_drop_tick, 1'b1);
        @(posedge clk);
        #1;
        bus.i_rx_done_tick = 1'b0;
        step(1'b1, 8'h66, 1'b1);
        make_pack(32'hA1B2C3D4, 32'hE5F60718, 8'h01);
        send_bytes(PN, 1, 1'b0);
        finish_reply(1'b0);

        // Reset after byte 6 of a pack, then a full pack.
        make_pack(32'hFFFFFFFF, 32'hFFFFFFFF, 8'h00);
        send_bytes(6, 1, 1'b0);
        do_reset();
        make_pack(32'h13572468, 32'h24681357, 8'h01);
        send_bytes(PN, 1, 1'b0);
        t = last_t;
        at_cycle(t + 3);
        chk("lit_ack_after_reset", bus.o_tx_data, 8'hA5);
        #1;
        finish_reply(1'b0);

        // Back-to-back packs for channels 0 and 2.
        make_pack(32'h11111111, 32'h22222222, 8'h00);
        send_bytes(PN, 0, 1'b0);
        finish_reply(1'b0);
        make_pack(32'h33333333, 32'h44444444, 8'h02);
        send_bytes(PN, 0, 1'b0);
        t = last_t;
        at_cycle(t + 2);
        chk("lit_load_ch2", bus.o_load, 3'b100);
        chk("lit_freq_ch2", bus.o_freq_pattern, 32'h44444444);
        #1;
        finish_reply(1'b0);

        // Randomized traffic.
        rand_busy = 1'b1;
        for (int n = 0; n < 80; n++) begin
            logic [7:0] ctl;
            ctl = ($urandom_range(0, 9) < 7) ? 8'($urandom_range(0, 2)) : 8'($urandom);
            make_pack($urandom, $urandom, ctl);
            if ($urandom_range(0, 9) == 0) begin
                send_bytes($urandom_range(1, PN - 1), 2, 1'b0);
                idle_to(last_c + TO + 2);
            end else begin
                send_bytes(PN, 2, 1'b1);
                if (!accepting) finish_reply(1'b1);
                else idle_to(last_c + TO + 2);
            end
        end
        rand_busy = 1'b0;
        repeat (5) step(1'b0, 8'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
